sensor_scanner: RTL and testbench

- Acquisition front-end that drives the four height sensors and supplies the stable sensor1..sensor4 bytes consumed by baggage_drop.
- Acts as the initiator of a shared four-phase req/ack sensor bus and polls the sensors in order 0..3 once per scan period.
- Publishes all four bytes atomically, with a valid pulse and per-sensor fault flags.
- Freezes its published values while drop_en is high, so a drop decision is never taken on half-updated data.

---
 rtl/baggage_pkg.sv | 18 +
 rtl/sensor_handshake.sv | 94 +++++++++
 rtl/sensor_scanner.sv | 119 +++++++++++
 tb/tb_sensor_scanner.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/baggage_pkg.sv
// Shared types and constants for the baggage-drop sensor front-end.
// Scanner FSM states and the published sensor byte format.
package baggage_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        WAIT_REL,
        COMMIT
    } state_e;

    localparam int NUM_SENSORS = 4;
    localparam int SENSOR_W    = 8;

    localparam logic [SENSOR_W-1:0] FAULT_VALUE = 8'd0;

endpackage

// File: rtl/sensor_handshake.sv
// Single-sensor four-phase req/ack engine with a per-edge timeout.
// done is a combinational pulse in the release cycle; start may chain.
module sensor_handshake
    import baggage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          sel,
    input  logic                sen_ack,
    input  logic [SENSOR_W-1:0] sen_data,
    output logic                sen_req,
    output logic [1:0]          sen_sel,
    output logic                done,
    output logic [SENSOR_W-1:0] data,
    output logic                timed_out
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_e              r_state;
    logic [TW-1:0]       r_tmo;
    logic [SENSOR_W-1:0] r_data;
    logic                r_to;
    logic                w_to_hit;

    assign w_to_hit = (r_tmo == TO_LAST);
    assign done     = (r_state == WAIT_REL) && (!sen_ack || w_to_hit);
    // Finishing release with ack still high can only mean a release timeout.
    assign timed_out = r_to || sen_ack;
    assign data      = timed_out ? FAULT_VALUE : r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            sen_req <= 1'b0;
            sen_sel <= 2'd0;
            r_tmo   <= '0;
            r_data  <= FAULT_VALUE;
            r_to    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        sen_sel <= sel;
                        r_tmo   <= '0;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    sen_req <= 1'b1;
                    r_tmo   <= '0;
                    r_to    <= 1'b0;
                    r_data  <= FAULT_VALUE;
                    r_state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (sen_ack) begin
                        r_data  <= sen_data;
                        sen_req <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= WAIT_REL;
                    end else if (w_to_hit) begin
                        r_to    <= 1'b1;
                        r_data  <= FAULT_VALUE;
                        sen_req <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= WAIT_REL;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (done) begin
                        r_tmo <= '0;
                        if (start) begin
                            sen_sel <= sel;
                            r_state <= REQ;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sensor_scanner.sv
// Periodic scanner over four height sensors; publishes all readings
// atomically and holds them while a drop decision is in progress.
module sensor_scanner
    import baggage_pkg::*;
#(
    parameter int SCAN_PERIOD = 1000,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   sen_req,
    output logic [1:0]             sen_sel,
    input  logic                   sen_ack,
    input  logic [SENSOR_W-1:0]    sen_data,
    input  logic                   drop_en,
    output logic [SENSOR_W-1:0]    sensor1,
    output logic [SENSOR_W-1:0]    sensor2,
    output logic [SENSOR_W-1:0]    sensor3,
    output logic [SENSOR_W-1:0]    sensor4,
    output logic [NUM_SENSORS-1:0] fault,
    output logic                   valid,
    output logic                   busy
);

    localparam int PW = $clog2(SCAN_PERIOD + 1);
    localparam logic [PW-1:0] P_MAX = PW'(SCAN_PERIOD);

    state_e                 r_state;
    logic [1:0]             r_idx;
    logic [PW-1:0]          r_period;
    logic [SENSOR_W-1:0]    r_shadow [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] r_flt;

    logic [PW-1:0]          w_period_nxt;
    logic                   w_expired;
    logic                   w_start;
    logic [1:0]             w_sel;
    logic                   w_done;
    logic [SENSOR_W-1:0]    w_data;
    logic                   w_timed_out;

    assign w_period_nxt = (r_period == P_MAX) ? r_period : r_period + 1'b1;
    assign w_expired    = (w_period_nxt == P_MAX);
    assign w_start      = ((r_state == IDLE) && w_expired)
                        || (w_done && (r_idx != 2'd3));
    assign w_sel        = (r_state == IDLE) ? 2'd0 : r_idx + 2'd1;

    sensor_handshake #(
        .TIMEOUT(TIMEOUT)
    ) u_hs (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_start),
        .sel      (w_sel),
        .sen_ack  (sen_ack),
        .sen_data (sen_data),
        .sen_req  (sen_req),
        .sen_sel  (sen_sel),
        .done     (w_done),
        .data     (w_data),
        .timed_out(w_timed_out)
    );

    // REQ here spans the whole handshake sequence run by u_hs over r_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= 2'd0;
            r_period <= P_MAX;
            r_shadow <= '{default: FAULT_VALUE};
            r_flt    <= '0;
            sensor1  <= '0;
            sensor2  <= '0;
            sensor3  <= '0;
            sensor4  <= '0;
            fault    <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_period <= w_period_nxt;
                    if (w_expired) begin
                        r_idx   <= 2'd0;
                        busy    <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (w_done) begin
                        r_shadow[r_idx] <= w_data;
                        r_flt[r_idx]    <= w_timed_out;
                        if (r_idx == 2'd3) begin
                            r_state <= COMMIT;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end
                COMMIT: begin
                    if (!drop_en) begin
                        sensor1  <= r_shadow[0];
                        sensor2  <= r_shadow[1];
                        sensor3  <= r_shadow[2];
                        sensor4  <= r_shadow[3];
                        fault    <= r_flt;
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                        r_period <= '0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_scanner.sv
// Directed bench for sensor_scanner with a simple behavioural sensor bus.
module tb_sensor_scanner;

    localparam int SP = 20;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sen_req;
    logic [1:0] sen_sel;
    logic       sen_ack = 1'b0;
    logic [7:0] sen_data = 8'h00;
    logic       drop_en = 1'b0;
    logic [7:0] sensor1, sensor2, sensor3, sensor4;
    logic [3:0] fault;
    logic       valid;
    logic       busy;

    logic [7:0] tbl [4];
    logic [3:0] dead = 4'b0000;
    logic       stuck_arm = 1'b0;
    logic       stuck = 1'b0;

    int n_err = 0;
    int n_checks = 0;

    sensor_scanner #(
        .SCAN_PERIOD(SP),
        .TIMEOUT    (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sen_req (sen_req),
        .sen_sel (sen_sel),
        .sen_ack (sen_ack),
        .sen_data(sen_data),
        .drop_en (drop_en),
        .sensor1 (sensor1),
        .sensor2 (sensor2),
        .sensor3 (sensor3),
        .sensor4 (sensor4),
        .fault   (fault),
        .valid   (valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Sensor side: answers half a cycle after req, data from tbl.
    always @(negedge clk) begin
        if (stuck_arm && sen_req && sen_sel == 2'd1) stuck = 1'b1;
        sen_ack  = stuck || (sen_req && !dead[sen_sel]);
        sen_data = tbl[sen_sel];
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_sig(input string tag, input int budget,
                            input int which);
        int n = 0;
        logic hit;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (which)
                0: hit = (valid === 1'b1);
                1: hit = (busy === 1'b1);
                default: hit = (sen_req === 1'b1 && sen_sel === 2'd2);
            endcase
        end
        check(tag, {63'd0, hit}, 64'd1);
    endtask

    initial begin
        int n;
        int k;
        int hi;
        tbl[0] = 8'h20; tbl[1] = 8'h40; tbl[2] = 8'h60; tbl[3] = 8'h80;

        repeat (3) @(negedge clk);
        check("rst_req", {63'd0, sen_req}, 64'd0);
        check("rst_sel", {62'd0, sen_sel}, 64'd0);
        check("rst_out", {sensor1, sensor2, sensor3, sensor4, fault, valid, busy},
              64'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check("start_busy", {63'd0, busy}, 64'd1);
        check("start_sel", {62'd0, sen_sel}, 64'd0);
        n = 0;
        while (valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scan_len", 64'(n), 64'd13);
        check("scan1_data", {sensor1, sensor2, sensor3, sensor4},
              64'h20406080);
        check("scan1_fault", {60'd0, fault}, 64'd0);
        check("scan1_busy", {63'd0, busy}, 64'd0);
        k = 1;
        @(negedge clk);
        check("valid_pulse", {63'd0, valid}, 64'd0);
        while (busy !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("period", 64'(k), 64'(SP));

        dead[2] = 1'b1;
        wait_sig("wait_sel2", 100, 2);
        hi = 0;
        while (sen_req === 1'b1 && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        check("timeout_len", 64'(hi), 64'(TO));
        wait_sig("wait_valid2", 100, 0);
        check("dead_data", {sensor1, sensor2, sensor3, sensor4},
              64'h20400080);
        check("dead_fault", {60'd0, fault}, 64'h4);
        dead[2] = 1'b0;

        wait_sig("wait_busy3", 100, 1);
        stuck_arm = 1'b1;
        wait_sig("wait_valid3", 300, 0);
        check("stuck_data", {sensor1, sensor2, sensor3, sensor4},
              64'h20000000);
        check("stuck_fault", {60'd0, fault}, 64'he);
        stuck_arm = 1'b0;
        stuck = 1'b0;

        tbl[0] = 8'h21; tbl[1] = 8'h41; tbl[2] = 8'h61; tbl[3] = 8'h81;
        wait_sig("wait_busy4", 100, 1);
        drop_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("hold", {valid, busy, fault, sensor1, sensor2, sensor3,
                  sensor4}, {26'd0, 1'b0, 1'b1, 4'he, 32'h20000000});
        end
        drop_en = 1'b0;
        @(negedge clk);
        check("hold_valid", {63'd0, valid}, 64'd1);
        check("hold_data", {sensor1, sensor2, sensor3, sensor4},
              64'h21416181);
        check("hold_fault", {60'd0, fault}, 64'd0);

        dead[2] = 1'b1;
        wait_sig("wait_busy5", 100, 1);
        wait_sig("wait_sel2b", 100, 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", {63'd0, sen_req}, 64'd0);
        check("arst_out", {sensor1, sensor2, sensor3, sensor4, fault, valid, busy},
              64'd0);
        dead[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tbl[3] = 8'h11;
        @(negedge clk);
        check("restart_busy", {63'd0, busy}, 64'd1);
        check("restart_sel", {62'd0, sen_sel}, 64'd0);
        wait_sig("wait_valid6", 100, 0);
        check("s4_first", {sensor1, sensor4}, 64'h2111);

        tbl[3] = 8'h99;
        n = 0;
        @(negedge clk);
        while (valid !== 1'b1 && n < 200) begin
            check("s4_before", {56'd0, sensor4}, 64'h11);
            @(negedge clk);
            n++;
        end
        check("s4_valid", {63'd0, valid}, 64'd1);
        check("s4_after", {56'd0, sensor4}, 64'h99);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
